sensor_conditioner: RTL and testbench

Conditions the two raw vehicle-detector inputs of the intersection into the clean `a`/`b` traffic-present signals consumed directly by `controllerFSM`. Each channel is synchronised, debounced, and stretched by a minimum hold time. A continuously asserted detector raises a sticky fault and fails safe by reporting traffic present. The block sits directly upstream of `controllerFSM`, and its `a`/`b` outputs connect port-for-port.

---
 rtl/sensor_pkg.sv | 31 +++
 rtl/sensor_channel.sv | 110 +++++++++++
 rtl/sensor_conditioner.sv | 50 +++++
 tb/tb_sensor_conditioner.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sensor_pkg
// Description : Shared state encoding, default timing constants and sizing
//               helper for the vehicle-detector conditioning channels.
// Revision    : 1.0 - initial release
// ============================================================================
package sensor_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        QUAL   = 3'd1,
        ACTIVE = 3'd2,
        HOLD   = 3'd3,
        FAULT  = 3'd4
    } sensor_state_t;

    localparam int unsigned c_DEBOUNCE_DEFAULT = 4;
    localparam int unsigned c_HOLD_DEFAULT     = 8;
    localparam int unsigned c_STUCK_DEFAULT    = 1024;

    function automatic int unsigned max3(input int unsigned x,
                                         input int unsigned y,
                                         input int unsigned z);
        int unsigned m;
        m = (x > y) ? x : y;
        return (m > z) ? m : z;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_channel.sv
`default_nettype none
// ============================================================================
// Module      : sensor_channel
// Description : One detector channel: two-flop synchroniser, debounce / hold /
//               stuck-detector FSM with a shared counter, registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_channel
    import sensor_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_DEFAULT,
    parameter int unsigned HOLD_CYCLES     = c_HOLD_DEFAULT,
    parameter int unsigned STUCK_CYCLES    = c_STUCK_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic det,
    output logic fault
);

    localparam int unsigned c_CNT_W =
        $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, STUCK_CYCLES)) + 1;

    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_DEB_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);
    // ACTIVE is entered with cnt=1, so the fault fires once the channel has
    // spent a full STUCK_CYCLES cycles in ACTIVE with the input still high.
    localparam logic [c_CNT_W-1:0] c_STK_LAST = c_CNT_W'(STUCK_CYCLES);

    logic                s1_q;
    logic                s_q;
    sensor_state_t       state_q;
    sensor_state_t       state_d;
    logic [c_CNT_W-1:0]  cnt_q;
    logic [c_CNT_W-1:0]  cnt_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q    <= 1'b0;
            s_q     <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            s1_q    <= raw;
            s_q     <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (s_q) begin
                    state_d = QUAL;
                    cnt_d   = c_ONE;
                end
            end
            QUAL: begin
                if (!s_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == c_DEB_LAST) begin
                    state_d = ACTIVE;
                    cnt_d   = c_ONE;
                end else begin
                    cnt_d   = cnt_q + c_ONE;
                end
            end
            ACTIVE: begin
                if (!s_q) begin
                    state_d = HOLD;
                    cnt_d   = c_ONE;
                end else if (cnt_q == c_STK_LAST) begin
                    state_d = FAULT;
                end else begin
                    cnt_d   = cnt_q + c_ONE;
                end
            end
            HOLD: begin
                // A retrigger restarts the stuck count from scratch.
                if (s_q) begin
                    state_d = ACTIVE;
                    cnt_d   = c_ONE;
                end else if (cnt_q == c_HLD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + c_ONE;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign det   = (state_q == ACTIVE) || (state_q == HOLD) || (state_q == FAULT);
    assign fault = (state_q == FAULT);

endmodule
`default_nettype wire

// File: rtl/sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : sensor_conditioner
// Description : Two independent detector channels producing the clean a/b
//               traffic-present inputs of controllerFSM plus stuck flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_conditioner
    import sensor_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_DEFAULT,
    parameter int unsigned HOLD_CYCLES     = c_HOLD_DEFAULT,
    parameter int unsigned STUCK_CYCLES    = c_STUCK_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_a,
    input  logic raw_b,
    output logic a,
    output logic b,
    output logic fault_a,
    output logic fault_b
);

    sensor_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_chan_a (
        .clk   (clk),
        .reset (reset),
        .raw   (raw_a),
        .det   (a),
        .fault (fault_a)
    );

    sensor_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_chan_b (
        .clk   (clk),
        .reset (reset),
        .raw   (raw_b),
        .det   (b),
        .fault (fault_b)
    );

endmodule
`default_nettype wire

// File: tb/tb_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_sensor_conditioner
// Description : Directed self-checking bench with a run-length reference model
//               of both detector channels, checked on every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sensor_conditioner;

    localparam int c_DEB   = 4;
    localparam int c_HOLD  = 8;
    localparam int c_STUCK = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic raw_a = 1'b0;
    logic raw_b = 1'b0;
    logic a;
    logic b;
    logic fault_a;
    logic fault_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sensor_conditioner #(
        .DEBOUNCE_CYCLES (c_DEB),
        .HOLD_CYCLES     (c_HOLD),
        .STUCK_CYCLES    (c_STUCK)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .raw_a   (raw_a),
        .raw_b   (raw_b),
        .a       (a),
        .b       (b),
        .fault_a (fault_a),
        .fault_b (fault_b)
    );

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the input seen by the channel is the raw value two
    // edges old; the output is decided from run lengths of that delayed input.
    logic m_s1[2];
    logic m_s[2];
    logic m_on[2];
    logic m_flt[2];
    int   m_hi[2];
    int   m_lo[2];
    int   m_act[2];
    logic m_raw[2];
    logic m_x;
    bit   model_valid = 1'b0;

    always @(posedge clk) begin
        m_raw[0] = raw_a;
        m_raw[1] = raw_b;
        for (int c = 0; c < 2; c++) begin
            if (!reset) begin
                m_s1[c] = 1'b0; m_s[c] = 1'b0; m_on[c] = 1'b0; m_flt[c] = 1'b0;
                m_hi[c] = 0;    m_lo[c] = 0;   m_act[c] = 0;
            end else begin
                m_x = m_s[c];
                if (m_flt[c]) begin
                    m_on[c] = 1'b1;
                end else if (!m_on[c]) begin
                    m_hi[c] = m_x ? m_hi[c] + 1 : 0;
                    if (m_hi[c] >= c_DEB) begin
                        m_on[c] = 1'b1; m_act[c] = 0; m_lo[c] = 0;
                    end
                end else if (m_x) begin
                    m_act[c] = (m_lo[c] > 0) ? 0 : m_act[c] + 1;
                    m_lo[c]  = 0;
                    if (m_act[c] >= c_STUCK) m_flt[c] = 1'b1;
                end else begin
                    m_lo[c] = m_lo[c] + 1;
                    if (m_lo[c] >= c_HOLD) begin
                        m_on[c] = 1'b0; m_hi[c] = 0; m_lo[c] = 0;
                    end
                end
                m_s[c]  = m_s1[c];
                m_s1[c] = m_raw[c];
            end
        end
        if (!reset) model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_a",       a,       m_on[0]);
            check("model_b",       b,       m_on[1]);
            check("model_fault_a", fault_a, m_flt[0]);
            check("model_fault_b", fault_b, m_flt[1]);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic seen;
    logic allhigh;

    initial begin
        // Reset held with both detectors high: everything stays low.
        reset = 1'b0; raw_a = 1'b1; raw_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("rst_a", a, 1'b0);
            check("rst_b", b, 1'b0);
            check("rst_fault_a", fault_a, 1'b0);
            check("rst_fault_b", fault_b, 1'b0);
        end
        reset = 1'b1;
        step(5);
        check("rise_early_a", a, 1'b0);
        check("rise_early_b", b, 1'b0);
        step(1);
        check("rise_a", a, 1'b1);
        check("rise_b", b, 1'b1);

        // Channel A released, channel B left stuck high.
        raw_a = 1'b0;
        step(9);
        check("hold_a", a, 1'b1);
        step(1);
        check("fall_a", a, 1'b0);
        step(21);
        check("pre_fault_b", fault_b, 1'b0);
        check("pre_fault_bb", b, 1'b1);
        step(1);
        check("fault_b", fault_b, 1'b1);
        raw_b = 1'b0;
        step(20);
        check("fault_sticky_b", b, 1'b1);
        check("fault_sticky_fb", fault_b, 1'b1);
        reset = 1'b0;
        step(1);
        check("fault_clr_b", b, 1'b0);
        check("fault_clr_fb", fault_b, 1'b0);
        reset = 1'b1;
        step(4);

        // Debounce: a 3-cycle pulse is rejected.
        seen = 1'b0;
        raw_a = 1'b1;
        for (int i = 0; i < 3; i++) begin step(1); seen |= a; end
        raw_a = 1'b0;
        for (int i = 0; i < 15; i++) begin step(1); seen |= a; end
        check("glitch3_a", seen, 1'b0);

        // A 4-cycle pulse is accepted, then held.
        raw_a = 1'b1;
        step(4);
        raw_a = 1'b0;
        step(1);
        check("pulse4_early", a, 1'b0);
        step(1);
        check("pulse4_rise", a, 1'b1);
        step(7);
        check("pulse4_hold", a, 1'b1);
        step(1);
        check("pulse4_fall", a, 1'b0);
        step(4);

        // Hold retrigger: 10 high, 5 low, 10 high keeps a continuous.
        raw_a = 1'b1;
        step(6);
        check("retrig_rise", a, 1'b1);
        allhigh = 1'b1;
        for (int i = 0; i < 4; i++) begin step(1); allhigh &= a; end
        raw_a = 1'b0;
        for (int i = 0; i < 5; i++) begin step(1); allhigh &= a; end
        raw_a = 1'b1;
        for (int i = 0; i < 10; i++) begin step(1); allhigh &= a; end
        raw_a = 1'b0;
        for (int i = 0; i < 8; i++) begin step(1); allhigh &= a; end
        check("retrig_continuous", allhigh, 1'b1);
        step(1);
        check("retrig_last_high", a, 1'b1);
        step(1);
        check("retrig_fall", a, 1'b0);
        step(4);

        // Independence: A chatters every 2 cycles, B has a clean pulse.
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            raw_a = ((i % 4) < 2);
            raw_b = (i < 10);
            step(1);
            seen |= a;
            if (i + 1 == 5)  check("indep_b_early", b, 1'b0);
            if (i + 1 == 6)  check("indep_b_rise",  b, 1'b1);
            if (i + 1 == 19) check("indep_b_hold",  b, 1'b1);
            if (i + 1 == 20) check("indep_b_fall",  b, 1'b0);
        end
        check("indep_a_quiet", seen, 1'b0);
        raw_a = 1'b0;
        raw_b = 1'b0;
        step(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
